fetch_queue: RTL and testbench

Elastic instruction queue between the memory fetch unit and the decode-side skid buffer. Accepts one fetched instruction word plus its PC per cycle and returns them in FIFO order, using the pipeline's stall-style handshake on both sides. Absorbs fetch bursts while decode is stalled. A single-cycle flush on branch redirect discards all queued entries.

---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Elastic instruction queue between the fetch unit and the decode-side skid
//   buffer. Holds up to DEPTH {pc, instr} pairs and returns them in FIFO order
//   using the stall-style handshake on both sides. A single-cycle flush
//   (branch redirect) discards everything queued.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   flush         discard all entries at the next edge
//   prev_stalled  high = upstream presents no word this cycle
//   in_instr      fetched instruction word
//   in_pc         PC of in_instr
//   stall_prev    high = queue full, upstream must hold its word
//   next_stalled  high = downstream does not accept this cycle
//   stall_next    high = no valid word offered downstream
//   out_instr     head instruction word (0 when empty)
//   out_pc        head PC (0 when empty)
//   count         occupancy, 0..DEPTH
//   overflow      sticky flag: upstream presented a word while held
module fetch_queue #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     prev_stalled,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  output logic                     stall_prev,
  input  logic                     next_stalled,
  output logic                     stall_next,
  output logic [WIDTH-1:0]         out_instr,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Pointers carry one wrap bit above the index bits.
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_overflow;
  logic [WIDTH-1:0]      r_mem_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc    [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[IW-1:0];
  assign w_rd_idx = r_rd_ptr[IW-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IW] != r_rd_ptr[IW]);

  // Handshake outputs come only from registered state (plus flush), so there
  // is no combinational path from either stall input to any output.
  assign stall_prev = w_full;
  assign stall_next = w_empty || flush;

  // A full queue refuses a push even if a pop happens in the same cycle.
  assign w_push = !prev_stalled && !w_full && !flush;
  assign w_pop  = !stall_next && !next_stalled;

  // Occupancy is the pointer distance modulo 2*DEPTH; it can never disagree
  // with the pointer-based full/empty decision.
  assign count    = r_wr_ptr - r_rd_ptr;
  assign overflow = r_overflow;

  assign out_instr = w_empty ? '0 : r_mem_instr[w_rd_idx];
  assign out_pc    = w_empty ? '0 : r_mem_pc[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        // No pop can occur during flush (stall_next is forced high), so only
        // the write pointer needs to collapse onto the read pointer.
        r_wr_ptr   <= r_rd_ptr;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        // Upstream offered a word while we were holding it off.
        if (!prev_stalled && w_full) r_overflow <= 1'b1;
      end
    end
  end

  // Storage is intentionally not reset; empty is decided by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[w_wr_idx] <= in_instr;
      r_mem_pc[w_wr_idx]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int W = 32;
  localparam int A = 32;
  localparam int D = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 prev_stalled = 1'b1;
  logic                 next_stalled = 1'b0;
  logic [W-1:0]         in_instr = '0;
  logic [A-1:0]         in_pc = '0;
  logic                 stall_prev;
  logic                 stall_next;
  logic [W-1:0]         out_instr;
  logic [A-1:0]         out_pc;
  logic [$clog2(D):0]   count;
  logic                 overflow;

  fetch_queue #(.WIDTH(W), .ADDR_WIDTH(A), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .prev_stalled (prev_stalled),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .stall_prev   (stall_prev),
    .next_stalled (next_stalled),
    .stall_next   (stall_next),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A-1:0] pc;
    logic [W-1:0] instr;
  } ent_t;

  ent_t sb[$];
  logic m_ovf = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [W-1:0] mk_instr(input logic [A-1:0] pc);
    logic [31:0] t;
    t = {~pc[15:0], pc[15:0]};
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 64'(count), 64'(sb.size()));
    check("stall_prev", 64'(stall_prev), 64'(sb.size() == D));
    check("stall_next", 64'(stall_next), 64'((sb.size() == 0) || flush));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (sb.size() == 0) begin
      check("out_pc_empty", 64'(out_pc), 64'(0));
      check("out_instr_empty", 64'(out_instr), 64'(0));
    end
  endtask

  task automatic drive(input logic ps, input logic ns, input logic fl, input logic [A-1:0] pc);
    prev_stalled = ps;
    next_stalled = ns;
    flush        = fl;
    in_pc        = pc;
    in_instr     = mk_instr(pc);
    #1;
  endtask

  // Compare current outputs, predict the edge, advance, then update the model.
  task automatic tick();
    logic m_push, m_pop;
    int   sz;
    ent_t e;
    sz = sb.size();
    check_state();
    m_push = !prev_stalled && (sz < D) && !flush;
    m_pop  = (sz > 0) && !flush && !next_stalled;
    if (m_pop) begin
      check("out_pc", 64'(out_pc), 64'(sb[0].pc));
      check("out_instr", 64'(out_instr), 64'(sb[0].instr));
    end
    e.pc    = in_pc;
    e.instr = in_instr;
    @(posedge clk);
    if (flush) begin
      m_ovf = 1'b0;
      sb.delete();
    end else begin
      if (!prev_stalled && sz == D) m_ovf = 1'b1;
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Reset and idle
    #1;
    check_state();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    next_stalled = 1'b1;
    #1;
    check_state();
    next_stalled = 1'b0;
    #1;
    check_state();
    rst_n = 1'b1;
    #1;

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i));
      tick();
    end
    check("fill_count", 64'(count), 64'(4));
    check("fill_stall_prev", 64'(stall_prev), 64'(1));
    drive(1'b1, 1'b1, 1'b0, 32'h110);
    tick();
    check("held_no_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      tick();
    end
    tick();

    // Streaming across pointer wraps
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h200 + 32'(4 * k));
      tick();
      check("stream_latency_pc", 64'(out_pc), 64'(32'h200 + 32'(4 * k)));
      check("stream_stall_next", 64'(stall_next), 64'(0));
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();

    // Full queue with simultaneous pop: push refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h310);
    tick();
    check("full_pop_count", 64'(count), 64'(3));
    drive(1'b0, 1'b1, 1'b0, 32'h310);
    tick();
    check("refill_count", 64'(count), 64'(4));

    // Flush with count 3 and a word offered
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h3FC);
    check("flush_stall_next", 64'(stall_next), 64'(1));
    tick();
    check("flush_count", 64'(count), 64'(0));
    check("flush_ovf", 64'(overflow), 64'(0));
    drive(1'b0, 1'b1, 1'b0, 32'h400);
    tick();
    check("post_flush_head", 64'(out_pc), 64'(32'h400));
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();

    // Overflow: sticky through traffic, cleared by flush
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h500 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h510);
    tick();
    check("ovf_set", 64'(overflow), 64'(1));
    for (int i = 0; i < 5; i++) begin
      drive(1'(i % 2), 1'((i + 1) % 2), 1'b0, 32'h520 + 32'(4 * i));
      tick();
      check("ovf_sticky", 64'(overflow), 64'(1));
    end
    drive(1'b1, 1'b0, 1'b1, '0);
    tick();
    check("ovf_cleared", 64'(overflow), 64'(0));
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();

    // Asynchronous reset mid-operation
    drive(1'b0, 1'b1, 1'b0, 32'h600);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h604);
    tick();
    drive(1'b1, 1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    check_state();
    check("async_rst_count", 64'(count), 64'(0));
    #1;
    rst_n = 1'b1;
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h700);
    tick();
    check("post_rst_head", 64'(out_pc), 64'(32'h700));
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
